// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------
// uart_pkg : shared FSM state type and boolean constants  (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------
// uart_baud_gen : 0..CLK_DIV-1 bit-period counter with tick  (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// ---------------------------------------------------------------
// uart_tx_drain : pops bytes from an upstream FIFO and serialises them 8N1-style  (rev 1.0)
// ---------------------------------------------------------------
`default_nettype none

module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int               BIT_W      = $clog2(DATA_W) + 1;
  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_W - 1);

  uart_tx_state_t    r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [BIT_W-1:0]  r_bitcnt;
  logic              r_txd;
  logic              r_busy;
  logic              w_tick;
  logic              w_clr;

  // Holding the counter clear until START makes every bit exactly CLK_DIV long.
  assign w_clr = (r_state == IDLE) || (r_state == FETCH);

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // rst gates the pop so no read is issued while the block is held in reset.
  assign fifo_rd_en = (r_state == IDLE) && !fifo_empty && !rst;
  assign frame_done = (r_state == STOP) && w_tick;
  assign txd        = r_txd;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_txd    <= TRUE;
      r_busy   <= FALSE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            r_state <= FETCH;
            r_busy  <= TRUE;
          end
        end
        FETCH: begin
          r_shreg  <= fifo_dout;
          r_bitcnt <= '0;
          r_txd    <= FALSE;
          r_state  <= START;
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shreg[0];
            r_shreg <= r_shreg >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bitcnt == c_LAST_BIT) begin
              r_txd   <= TRUE;
              r_state <= STOP;
            end else begin
              r_txd    <= r_shreg[0];
              r_shreg  <= r_shreg >> 1;
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_busy  <= FALSE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= TRUE;
          r_busy  <= FALSE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// Scoreboard bench: FIFO model feeds the DUT, a UART receiver decodes txd and checks against popped bytes.
`default_nettype none

module tb_uart_tx_drain;

  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 8;
  localparam int FRAME   = 2 + (DATA_W + 2) * CLK_DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              txd;
  logic              busy;
  logic              frame_done;

  uart_tx_drain #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_q[$];
  int                pop_times[$];
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                npops = 0;
  int                nrx = 0;
  int                last_pop = 0;
  bit                have_pop = 1'b0;
  bit                rx_active = 1'b0;
  int                rx_n = 0;
  logic [DATA_W-1:0] rx_byte = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFO model: data valid the cycle after the pop, registered empty flag.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: cycle-level expectations plus a bench UART receiver.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_fd;
    bit exp_rd;
    if (rst) begin
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      have_pop  = 1'b0;
      rx_active = 1'b0;
      exp_q.delete();
    end else begin
      exp_busy = have_pop && (cyc > last_pop) && (cyc <= last_pop + FRAME - 1);
      exp_fd   = have_pop && (cyc == last_pop + FRAME - 1);
      exp_rd   = !exp_busy && !fifo_empty;
      chk("rd_en", fifo_rd_en, exp_rd);
      chk("busy", busy, exp_busy);
      chk("frame_done", frame_done, exp_fd);
      if (!exp_busy || cyc == last_pop + 1) chk("txd_idle", txd, 1);
      if (fifo_rd_en && fq.size() > 0) begin
        exp_q.push_back(fq[0]);
        last_pop = cyc;
        have_pop = 1'b1;
        pop_times.push_back(cyc);
        npops++;
      end
      if (!rx_active) begin
        if (txd == 1'b0) begin
          rx_active = 1'b1;
          rx_n      = 0;
          chk("start_time", cyc, have_pop ? last_pop + 2 : -1);
        end
      end else begin
        rx_n++;
        if (rx_n >= 5 && rx_n <= 4 * DATA_W + 1 && ((rx_n - 5) % 4) == 0)
          rx_byte[(rx_n - 5) / 4] = txd;
        if (rx_n == 4 * DATA_W + 5) begin
          chk("stop_bit", txd, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", rx_byte, -1);
          end else begin
            chk("rx_byte", rx_byte, exp_q.pop_front());
          end
          nrx++;
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    fq.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t = 0;
    while ((fq.size() != 0 || busy || exp_q.size() != 0 || rx_active || !fifo_empty) && t < limit) begin
      wait_cycles(1);
      t++;
    end
    chk(name, (t < limit) ? 1 : 0, 1);
    wait_cycles(3);
  endtask

  initial begin
    int n0;
    int r0;
    int p0;
    int t;
    rst = 1'b1;
    wait_cycles(2);
    push(8'hC3);
    wait_cycles(4);
    rst = 1'b0;
    wait_idle("idle_after_reset", 500);

    // Empty FIFO for 200 cycles
    n0 = npops;
    wait_cycles(200);
    chk("empty_no_pop", npops - n0, 0);

    // Single byte
    n0 = npops; r0 = nrx;
    push(8'h55);
    wait_idle("idle_single", 500);
    chk("single_pops", npops - n0, 1);
    chk("single_rx", nrx - r0, 1);

    // Burst of three
    p0 = pop_times.size(); r0 = nrx;
    push(8'h01); push(8'h80); push(8'hFF);
    wait_idle("idle_burst", 1000);
    chk("burst_pops", pop_times.size() - p0, 3);
    if (pop_times.size() - p0 == 3) begin
      chk("burst_gap1", pop_times[p0 + 1] - pop_times[p0], FRAME);
      chk("burst_gap2", pop_times[p0 + 2] - pop_times[p0 + 1], FRAME);
    end
    chk("burst_rx", nrx - r0, 3);

    // Reset during DATA bit 3 of 0xA5
    n0 = npops; r0 = nrx;
    push(8'hA5);
    t = 0;
    while (npops == n0 && t < 200) begin
      wait_cycles(1);
      t++;
    end
    chk("a5_popped", npops - n0, 1);
    repeat (19) @(posedge clk);
    #2;
    chk("pre_rst_txd_bit3", txd, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd_en", fifo_rd_en, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'h5A);
    wait_idle("idle_after_midrst", 500);
    chk("midrst_rx", nrx - r0, 1);

    // Empty rises right after the pop
    n0 = npops; r0 = nrx;
    push(8'h3C);
    wait_idle("idle_3c", 500);
    wait_cycles(60);
    chk("3c_pops", npops - n0, 1);
    chk("3c_rx", nrx - r0, 1);

    // 256 random bytes at random arrival times
    n0 = npops; r0 = nrx;
    for (int i = 0; i < 256; i++) begin
      push(DATA_W'($urandom_range(0, 255)));
      wait_cycles($urandom_range(0, 60));
    end
    wait_idle("idle_random", 20000);
    chk("random_pops", npops - n0, 256);
    chk("random_rx", nrx - r0, 256);
    chk("random_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 Parameter CLK_DIV, default 16: number of clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8: bits per frame; equals the FIFO data width.
REQ-003 clk  input  1  single clock for all logic; it is the read clock of the upstream FIFO.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag, synchronous to clk.
REQ-006 fifo_rd_en  output  1  pop strobe to the upstream FIFO.
REQ-007 fifo_dout  input  DATA_W  upstream FIFO read data, valid on the cycle after fifo_rd_en is high.
REQ-008 txd  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is being fetched or shifted.
REQ-010 frame_done  output  1  one-cycle pulse on the last clk of a stop bit.

Function
REQ-011 The FSM SHALL have exactly these states: IDLE, FETCH, START, DATA, STOP.
REQ-012 IDLE: when fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to FETCH; otherwise stay in IDLE with fifo_rd_en=0.
REQ-013 fifo_rd_en SHALL be combinational from (state==IDLE && !fifo_empty), and never high in any other state.
REQ-014 FETCH: lasts one cycle; latch fifo_dout into the shift register, clear the baud counter and bit counter, and go to START.
REQ-015 START: txd=0 for CLK_DIV cycles, then go to DATA.
REQ-016 DATA: shift out DATA_W bits LSB first, each for CLK_DIV cycles; after the last bit go to STOP.
REQ-017 STOP: txd=1 for CLK_DIV cycles; pulse frame_done on the final cycle, then go to IDLE.
REQ-018 The baud counter SHALL count 0..CLK_DIV-1, with wrap generating the bit tick; its width is $clog2(CLK_DIV); CLK_DIV-1 SHALL never overflow it.
REQ-019 The bit counter SHALL count 0..DATA_W-1; its width is $clog2(DATA_W)+1.
REQ-020 txd SHALL be registered, with no combinational glitches; txd=1 in IDLE and FETCH.
REQ-021 busy=1 in FETCH, START, DATA, and STOP; busy=0 in IDLE.
REQ-022 Frame period, from the fifo_rd_en cycle to the next possible fifo_rd_en: exactly 2 + (DATA_W+2)*CLK_DIV cycles (the IDLE pop cycle + FETCH + bits).
REQ-023 A back-to-back FIFO with fifo_empty=0 continuously SHALL produce frames separated by exactly 2 cycles of txd=1 beyond the stop bit.
REQ-024 fifo_empty rising after the pop SHALL NOT affect the frame in progress.
REQ-025 fifo_empty SHALL be ignored outside IDLE.

Reset
REQ-026 While rst=1: state=IDLE, txd=1, busy=0, frame_done=0, fifo_rd_en=0, and all counters and the shift register are 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with txd returning to 1 asynchronously; no pop occurs until the first clk edge after rst deasserts with fifo_empty=0.

Structure
REQ-028 The shared package uart_pkg SHALL hold the state enum typedef (uart_tx_state_t) and the TRUE/FALSE constants.
REQ-029 The baud counter SHALL be the sub-module uart_baud_gen, with ports clk, rst, clr, and tick; tick is high on the cycle the counter equals CLK_DIV-1.
REQ-030 No other sub-modules are permitted; the block is instantiated directly after ip_fifo on its read side.

Verification (CLK_DIV=4, DATA_W=8)
REQ-031 Single byte: preload FIFO with 0x55 -> exactly one fifo_rd_en pulse; txd = 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each bit held 4 clk; frame_done pulses 41 cycles after the pop.
REQ-032 Empty FIFO: fifo_empty=1 for 200 cycles -> fifo_rd_en=0, txd=1, busy=0 throughout.
REQ-033 Burst: FIFO holds 0x01,0x80,0xFF -> three pops spaced exactly 42 cycles apart; the decoded bytes equal the input sequence.
REQ-034 Mid-frame reset: assert rst in DATA bit 3 of 0xA5 -> txd=1 within the same cycle and state=IDLE; after release with FIFO non-empty, the next pop yields a complete frame.
REQ-035 Empty during frame: fifo_empty rises 1 cycle after the pop of 0x3C -> the full frame 0x3C completes, followed by no further pops.
REQ-036 Scoreboard: 256 random bytes through ip_fifo into this block; a bench UART receiver SHALL match the sequence with zero loss or duplication.
